// File: rtl/hp_mc_if.sv
// Sample-stream bus for hp_mc: input handshake, coefficient/bypass/clear
// controls, and output handshake. The block uses the slave modport; the
// channel scheduler (or a bench) uses the master modport.
interface hp_mc_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CHAN_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic [CHAN_W-1:0] i_chan;
  logic [COEF_W-1:0] i_coef;
  logic              i_bypass;
  logic              i_clr;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic [CHAN_W-1:0] o_chan;

  modport slave (
    input  i_valid, i_data, i_chan, i_coef, i_bypass, i_clr, i_ready,
    output o_ready, o_valid, o_data, o_chan
  );

  modport master (
    output i_valid, i_data, i_chan, i_coef, i_bypass, i_clr, i_ready,
    input  o_ready, o_valid, o_data, o_chan
  );
endinterface

// File: rtl/hp_mc.sv
// Multi-channel first-order IIR high-pass filter, y[n] = a*(y[n-1] + x[n] - x[n-1]).
// Channels are time-multiplexed through one datapath; each channel keeps its own
// x_prev/y_prev. One sample is in flight at a time (IDLE -> MAC -> OUT).
module hp_mc #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CHAN_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input logic    i_clk,
  input logic    i_rst,
  hp_mc_if.slave bus
);

  // Difference term needs two guard bits; product adds the zero-extended coefficient.
  localparam int unsigned DW = DATA_W + 2;
  localparam int unsigned PW = DW + COEF_W + 1;

  localparam logic signed [PW-1:0] RndHalf = {{(PW-1){1'b0}}, 1'b1} << (COEF_W - 2);
  localparam logic signed [PW-1:0] YMax    = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW-1:0] YMin    = {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  state_e state_q, state_d;

  logic signed [DATA_W-1:0] x_q;
  logic        [CHAN_W-1:0] ch_q;
  logic        [COEF_W-1:0] a_q;
  logic                     byp_q;

  logic signed [DATA_W-1:0] x_prev_q [NUM_CH];
  logic signed [DATA_W-1:0] y_prev_q [NUM_CH];

  logic        [DATA_W-1:0] data_q;
  logic        [CHAN_W-1:0] chan_q;

  logic                     in_range;
  logic signed [DATA_W-1:0] xp_rd, yp_rd;
  logic signed [DW-1:0]     d;
  logic signed [PW-1:0]     d_ext, a_ext, p, r;
  logic signed [DATA_W-1:0] y_sat, y_out, y_state;
  logic                     accept;

  assign accept      = (state_q == StIdle) && bus.i_valid;
  assign bus.o_ready = (state_q == StIdle);
  assign bus.o_valid = (state_q == StOut);
  assign bus.o_data  = data_q;
  assign bus.o_chan  = chan_q;

  // Next-state logic: fixed three-cycle sample pipeline, OUT waits on downstream.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.i_valid) state_d = StMac;
      StMac:   state_d = StOut;
      StOut:   if (bus.i_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the sample and its per-sample controls on accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x_q   <= '0;
      ch_q  <= '0;
      a_q   <= '0;
      byp_q <= 1'b0;
    end else if (accept) begin
      x_q   <= bus.i_data;
      ch_q  <= bus.i_chan;
      a_q   <= bus.i_coef;
      byp_q <= bus.i_bypass;
    end
  end

  // Datapath: difference, Q1 multiply, round-half-up shift, saturate.
  always_comb begin
    in_range = ({{(32-CHAN_W){1'b0}}, ch_q} < NUM_CH);
    xp_rd    = in_range ? x_prev_q[ch_q] : '0;
    yp_rd    = in_range ? y_prev_q[ch_q] : '0;
    d        = {{2{yp_rd[DATA_W-1]}}, yp_rd} + {{2{x_q[DATA_W-1]}}, x_q}
             - {{2{xp_rd[DATA_W-1]}}, xp_rd};
    d_ext    = {{(PW-DW){d[DW-1]}}, d};
    a_ext    = {{(PW-COEF_W){1'b0}}, a_q};
    p        = d_ext * a_ext;
    r        = (p + RndHalf) >>> (COEF_W - 1);
    if (r > YMax) begin
      y_sat = YMax[DATA_W-1:0];
    end else if (r < YMin) begin
      y_sat = YMin[DATA_W-1:0];
    end else begin
      y_sat = r[DATA_W-1:0];
    end
    // Out-of-range channels produce zero regardless of bypass.
    y_out   = !in_range ? '0 : (byp_q ? x_q : y_sat);
    // Bypass leaves y_prev at 0 so leaving bypass starts from a bounded step.
    y_state = byp_q ? '0 : y_sat;
  end

  // Per-channel state; clear has priority over the MAC write-back.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        x_prev_q[i] <= '0;
        y_prev_q[i] <= '0;
      end
    end else if (bus.i_clr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        x_prev_q[i] <= '0;
        y_prev_q[i] <= '0;
      end
    end else if ((state_q == StMac) && in_range) begin
      x_prev_q[ch_q] <= x_q;
      y_prev_q[ch_q] <= y_state;
    end
  end

  // Output register, loaded once per sample and held through backpressure.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q <= '0;
      chan_q <= '0;
    end else if (state_q == StMac) begin
      data_q <= y_out;
      chan_q <= ch_q;
    end
  end

endmodule
